// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mul_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t;
  localparam int WIDTH = 10;
  localparam int CNT_W = $clog2(WIDTH + 1);
endpackage

// File: rtl/mul_datapath.sv
// Shift-add datapath: multiplicand, multiplier and accumulator registers
// driven by clear/load/step strobes from the controlling FSM.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int W = mul_pkg::WIDTH
) (
  input  logic           clk,
  input  logic           clr_i,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] acc_o,
  output logic           mplr_zero_o
);
  logic [2*W-1:0] mcand_q, acc_q;
  logic [W-1:0]   mplr_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
    end else if (load_i) begin
      mcand_q <= {{W{1'b0}}, a_i};
      mplr_q  <= b_i;
      acc_q   <= '0;
    end else if (step_i) begin
      // 2*W-bit accumulator holds the full product, so it can never wrap
      if (mplr_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
    end
  end

  assign acc_o       = acc_q;
  assign mplr_zero_o = (mplr_q == '0);
endmodule

// File: rtl/seq_multiplier.sv
// Unsigned radix-2 sequential multiplier: FSM, iteration counter and output registers.
// Optional MUL_EARLY_TERM_EN ends CALC once the remaining multiplier bits are all zero.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = mul_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             start,
  output logic [WIDTH-1:0] p_out,
  output logic             ovf,
  output logic             busy,
  output logic             valid
);
  localparam int CW = $clog2(WIDTH + 1);

  mul_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] p_q;
  logic             ovf_q, busy_q, valid_q;
  logic [2*WIDTH-1:0] acc;
  logic             mplr_zero, fin, load, step;

  always_comb begin
    fin = (cnt_q == CW'(WIDTH));
`ifdef MUL_EARLY_TERM_EN
    // at least one iteration always runs, so b=0 still takes one CALC step
    fin = fin || ((cnt_q != '0) && mplr_zero);
`endif
    load = (state_q != CALC) && start;
    step = (state_q == CALC) && !fin;
  end

  mul_datapath #(.W(WIDTH)) u_dp (
    .clk         (clk),
    .clr_i       (sclr),
    .load_i      (load),
    .step_i      (step),
    .a_i         (a_in),
    .b_i         (b_in),
    .acc_o       (acc),
    .mplr_zero_o (mplr_zero)
  );

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          valid_q <= 1'b0;
          if (start) begin
            state_q <= CALC;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          if (fin) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            p_q     <= acc[WIDTH-1:0];
            ovf_q   <= |acc[2*WIDTH-1:WIDTH];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign p_out = p_q;
  assign ovf   = ovf_q;
  assign busy  = busy_q;
  assign valid = valid_q;
endmodule
